// File: rtl/rx_line_bank_ctrl.sv
// rx_line_bank_ctrl: collects received characters into lines and publishes
// them to the display through a ping-pong pair of line banks. A completed
// line is only swapped in while the display is between frames.
// Build option: define RX_ERR_SUBST_EN to store parity-error characters as
// '?' instead of dropping the whole corrupted line.
module rx_line_bank_ctrl #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  TERM    = 8'h0D
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    input  logic          char_err,
    input  logic          frame_busy,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   rd_len,
    output logic          line_ready,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int unsigned DEPTH = 2 * MAX_LEN;
    localparam logic [7:0]  SPACE = 8'h20;
    localparam logic [7:0]  SUBST = 8'h3F;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        DISCARD   = 2'd1,
        PEND_SWAP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          rd_bank;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW:0]   pend_len, pend_len_nxt;
    logic [7:0]    mem [DEPTH];

    logic          store;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          do_swap;
    logic          ovf_set;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        pend_len_nxt = pend_len;
        store        = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = char_data;
        do_swap      = 1'b0;
        ovf_set      = 1'b0;

        case (state)
            FILL: begin
                if (char_valid) begin
                    if (char_err) begin
`ifdef RX_ERR_SUBST_EN
                        store     = 1'b1;
                        mem_wdata = SUBST;
`else
                        wr_ptr_nxt = '0;
                        state_nxt  = DISCARD;
`endif
                    end else if (char_data == TERM) begin
                        // Empty lines are never published
                        if (wr_ptr != '0) begin
                            pend_len_nxt = {1'b0, wr_ptr};
                            state_nxt    = PEND_SWAP;
                        end
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (char_valid && !char_err && char_data == TERM) begin
                    wr_ptr_nxt = '0;
                    state_nxt  = FILL;
                end
            end
            PEND_SWAP: begin
                if (char_valid) ovf_set = 1'b1;
                if (!frame_busy) begin
                    do_swap    = 1'b1;
                    wr_ptr_nxt = '0;
                    state_nxt  = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase

        // A full line terminates itself so wr_ptr never has to wrap
        if (store) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (wr_ptr == AW'(MAX_LEN - 1)) begin
                pend_len_nxt = (AW + 1)'(MAX_LEN);
                state_nxt    = PEND_SWAP;
            end
        end
    end

    // Write pointer, pending length, bank ownership and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            pend_len   <= '0;
            rd_bank    <= 1'b1;
            rd_len     <= '0;
            line_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            pend_len   <= pend_len_nxt;
            line_ready <= do_swap;
            if (do_swap) begin
                rd_bank <= ~rd_bank;
                rd_len  <= pend_len;
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Line storage; the write bank is always the one not being displayed
    always_ff @(posedge clk) begin
        if (mem_we) mem[{~rd_bank, wr_ptr}] <= mem_wdata;
    end

    // Display read port; addresses past the line end read as blanks
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     rd_data <= SPACE;
        else if ({1'b0, rd_addr} < rd_len) rd_data <= mem[{rd_bank, rd_addr}];
        else                           rd_data <= SPACE;
    end

endmodule

// File: tb/tb_rx_line_bank_ctrl.sv
// Bench for rx_line_bank_ctrl: expected line lengths are queued when a line
// is sent and checked when line_ready fires; expected read data is queued
// when an address is driven and checked one cycle later.
module tb_rx_line_bank_ctrl;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned AW      = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_err;
    logic          frame_busy;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   rd_len;
    logic          line_ready;
    logic          overflow;
    logic          ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW:0] len_q[$];
    logic [7:0]  data_q[$];

    rx_line_bank_ctrl #(.MAX_LEN(MAX_LEN), .AW(AW), .TERM(8'h0D)) dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_err   (char_err),
        .frame_busy (frame_busy),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_len     (rd_len),
        .line_ready (line_ready),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every line_ready pulse must match a queued publication
    always @(posedge clk) begin
        #1;
        if (!reset && line_ready) begin
            if (len_q.size() == 0) chk("unexpected_line_ready", 32'(line_ready), 32'd0);
            else                   chk("rd_len_at_swap", 32'(rd_len), 32'(len_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c, input logic e);
        char_valid = 1'b1;
        char_data  = c;
        char_err   = e;
        @(negedge clk);
        char_valid = 1'b0;
        char_err   = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp);
        rd_addr = a;
        data_q.push_back(exp);
        @(posedge clk);
        #1;
        chk("rd_data", 32'(rd_data), 32'(data_q.pop_front()));
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_err   = 1'b0;
        frame_busy = 1'b0;
        rd_addr    = '0;
        ovf_clr    = 1'b0;
        idle(3);
        chk("reset_rd_len", 32'(rd_len), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'h20);
        chk("reset_line_ready", 32'(line_ready), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        idle(2);
        rd(0, 8'h20);

        // "HI" + CR
        len_q.push_back(5'd2);
        send(8'h48, 1'b0); send(8'h49, 1'b0); send(8'h0D, 1'b0);
        idle(4);
        rd(0, 8'h48); rd(1, 8'h49); rd(2, 8'h20);

        // Full 16-character line swaps without a terminator
        len_q.push_back(5'd16);
        for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1'b0);
        idle(4);
        rd(15, 8'h50); rd(0, 8'h41);
        send(8'h0D, 1'b0);
        idle(4);
        chk("rd_len_after_empty_term", 32'(rd_len), 32'd16);

        // Swap held off by frame_busy; extra character overflows
        frame_busy = 1'b1;
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h0D, 1'b0);
        send(8'h43, 1'b0);
        idle(4);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("rd_len_held", 32'(rd_len), 32'd16);
        len_q.push_back(5'd2);
        frame_busy = 1'b0;
        idle(3);
        rd(0, 8'h41); rd(1, 8'h42); rd(2, 8'h20);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("overflow_clr", 32'(overflow), 32'd0);

        // Set beats clear in the same cycle
        frame_busy = 1'b1;
        send(8'h44, 1'b0); send(8'h0D, 1'b0);
        ovf_clr = 1'b1;
        send(8'h45, 1'b0);
        ovf_clr = 1'b0;
        chk("overflow_set_wins", 32'(overflow), 32'd1);
        len_q.push_back(5'd1);
        frame_busy = 1'b0;
        idle(3);
        rd(0, 8'h44);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("overflow_clr2", 32'(overflow), 32'd0);

        // Parity error inside a line
`ifdef RX_ERR_SUBST_EN
        len_q.push_back(5'd3);
`endif
        send(8'h58, 1'b1); send(8'h59, 1'b0); send(8'h5A, 1'b0); send(8'h0D, 1'b0);
        idle(4);
`ifdef RX_ERR_SUBST_EN
        chk("rd_len_subst", 32'(rd_len), 32'd3);
        rd(0, 8'h3F); rd(1, 8'h59); rd(2, 8'h5A);
`else
        chk("rd_len_discard", 32'(rd_len), 32'd1);
        rd(0, 8'h44);
`endif

        // Consecutive lines alternate banks
        len_q.push_back(5'd1);
        send(8'h41, 1'b0); send(8'h0D, 1'b0);
        idle(3);
        rd(0, 8'h41); rd(1, 8'h20);
        len_q.push_back(5'd2);
        send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h0D, 1'b0);
        idle(3);
        rd(0, 8'h42); rd(1, 8'h43);

        // Reset while a swap is pending
        frame_busy = 1'b1;
        send(8'h51, 1'b0); send(8'h0D, 1'b0); send(8'h52, 1'b0);
        chk("overflow_before_reset", 32'(overflow), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_rd_len", 32'(rd_len), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'h20);
        chk("midrst_line_ready", 32'(line_ready), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        idle(2);
        frame_busy = 1'b0;
        reset = 1'b0;
        idle(5);
        chk("post_reset_rd_len", 32'(rd_len), 32'd0);
        rd(0, 8'h20);

        chk("pending_swaps_left", 32'(len_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
